// File: rtl/onewire_crc8_chk.sv
// rtl/onewire_crc8_chk.sv - 1-Wire Dallas/Maxim CRC8 receive-side frame checker
// Shifts in NBYTES bytes LSB-first, runs the reflected CRC8 serially and reports the result.

module onewire_crc8_chk #(
   parameter int          NBYTES   = 8,
   parameter logic [7:0]  CRC_INIT = 8'h00
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  bit_valid,
   input  logic                  bit_in,
   output logic                  busy,
   output logic                  done,
   output logic                  crc_ok,
   output logic [7:0]            crc_calc,
   output logic [7:0]            crc_rx,
   output logic [8*NBYTES-1:0]   frame,
   output logic                  all_zero
);

   localparam int NBITS = 8 * NBYTES;
   localparam int IW    = $clog2(NBITS);
   localparam int CW    = IW + 1;

   localparam logic [CW-1:0] LAST_BIT     = CW'(NBITS - 1);
   localparam logic [CW-1:0] PAYLOAD_LAST = CW'(NBITS - 9);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic [7:0]    crc;
   logic          fb;
   logic [7:0]    crc_next;

   always_comb begin
      fb       = crc[0] ^ bit_in;
      crc_next = {1'b0, crc[7:1]} ^ (fb ? 8'h8C : 8'h00);
   end

   assign crc_rx = frame[NBITS-1 -: 8];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         crc      <= CRC_INIT;
         busy     <= 1'b0;
         done     <= 1'b0;
         crc_ok   <= 1'b0;
         crc_calc <= 8'h00;
         frame    <= '0;
         all_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         // start overrides abort and any bit arriving in the same cycle
         if (start) begin
            state    <= SHIFT;
            count    <= '0;
            crc      <= CRC_INIT;
            frame    <= '0;
            all_zero <= 1'b1;
            crc_ok   <= 1'b0;
            busy     <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  state <= IDLE;
               end
               SHIFT: begin
                  if (abort) begin
                     state  <= IDLE;
                     busy   <= 1'b0;
                     crc_ok <= 1'b0;
                  end else if (bit_valid) begin
                     crc                <= crc_next;
                     frame[count[IW-1:0]] <= bit_in;
                     all_zero           <= all_zero & ~bit_in;
                     count              <= count + CW'(1);
                     // CRC after the final payload bit is the computed CRC
                     if (count == PAYLOAD_LAST)
                        crc_calc <= crc_next;
                     if (count == LAST_BIT) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        crc_ok <= (crc_next == 8'h00);
                     end
                  end
               end
               DONE: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_onewire_crc8_chk.sv
// tb/tb_onewire_crc8_chk.sv - scoreboard bench for onewire_crc8_chk (NBYTES=8 and NBYTES=2)

module tb_onewire_crc8_chk;

   typedef struct {
      logic         ok;
      logic         az;
      logic [7:0]   calc;
      bit           calc_ne;
      logic [7:0]   rx;
      logic [127:0] fr;
      int           cyc;
   } exp_t;

   localparam logic [63:0] ROM     = 64'hA2000000_01B81C02;
   localparam logic [63:0] ROM_BAD = 64'hA2000000_00B81C02;
   localparam logic [15:0] F2      = 16'h5E01;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0, abort = 1'b0, bit_valid = 1'b0, bit_in = 1'b0;
   logic busy, done, crc_ok, all_zero;
   logic [7:0]  crc_calc, crc_rx;
   logic [63:0] frame;

   logic rst2 = 1'b0;
   logic start2 = 1'b0, abort2 = 1'b0, bit_valid2 = 1'b0, bit_in2 = 1'b0;
   logic busy2, done2, crc_ok2, all_zero2;
   logic [7:0]  crc_calc2, crc_rx2;
   logic [15:0] frame2;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   exp_t q1[$];
   exp_t q2[$];

   onewire_crc8_chk #(.NBYTES(8), .CRC_INIT(8'h00)) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .bit_valid(bit_valid), .bit_in(bit_in), .busy(busy), .done(done),
      .crc_ok(crc_ok), .crc_calc(crc_calc), .crc_rx(crc_rx),
      .frame(frame), .all_zero(all_zero)
   );

   onewire_crc8_chk #(.NBYTES(2), .CRC_INIT(8'h00)) u_dut2 (
      .clk(clk), .rst(rst2), .start(start2), .abort(abort2),
      .bit_valid(bit_valid2), .bit_in(bit_in2), .busy(busy2), .done(done2),
      .crc_ok(crc_ok2), .crc_calc(crc_calc2), .crc_rx(crc_rx2),
      .frame(frame2), .all_zero(all_zero2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic compare(input string tag, input exp_t e, input logic ok, input logic az,
                          input logic [7:0] calc, input logic [7:0] rx,
                          input logic [127:0] fr, input logic bsy);
      chk({tag, "_done_latency"}, 128'(cyc), 128'(e.cyc));
      chk({tag, "_crc_ok"}, 128'(ok), 128'(e.ok));
      chk({tag, "_all_zero"}, 128'(az), 128'(e.az));
      chk({tag, "_crc_rx"}, 128'(rx), 128'(e.rx));
      chk({tag, "_frame"}, fr, e.fr);
      chk({tag, "_busy_at_done"}, 128'(bsy), 128'(0));
      if (e.calc_ne) begin
         checks++;
         if (calc === e.calc) begin
            errors++;
            $display("FAIL %s_crc_calc_differs actual=%h required=not %h", tag, calc, e.calc);
         end
      end else begin
         chk({tag, "_crc_calc"}, 128'(calc), 128'(e.calc));
      end
   endtask

   // monitors: every done pulse must match the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut8_unexpected_done actual=1 required=0");
         end else begin
            e = q1.pop_front();
            compare("dut8", e, crc_ok, all_zero, crc_calc, crc_rx, 128'(frame), busy);
         end
      end
      if (done2) begin
         if (q2.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut2_unexpected_done actual=1 required=0");
         end else begin
            e = q2.pop_front();
            compare("dut2", e, crc_ok2, all_zero2, crc_calc2, crc_rx2, 128'(frame2), busy2);
         end
      end
   end

   task automatic push1(input logic ok, input logic az, input logic [7:0] calc,
                        input bit ne, input logic [7:0] rx, input logic [63:0] fr);
      exp_t e;
      e.ok = ok; e.az = az; e.calc = calc; e.calc_ne = ne; e.rx = rx;
      e.fr = 128'(fr); e.cyc = cyc;
      q1.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start1();
      start = 1'b1;
      idle(1);
      start = 1'b0;
   endtask

   task automatic send1(input logic [63:0] d, input int first, input int n, input int gap);
      for (int i = first; i < first + n; i++) begin
         bit_valid = 1'b1;
         bit_in    = d[i];
         idle(1);
         bit_valid = 1'b0;
         if (i != first + n - 1) idle(gap - 1);
      end
   endtask

   task automatic send2(input logic [15:0] d, input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         bit_valid2 = 1'b1;
         bit_in2    = d[i];
         idle(1);
         bit_valid2 = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      #2;
      rst  = 1'b1;
      rst2 = 1'b1;
      #1;
      chk("reset_busy", 128'(busy), 128'(0));
      chk("reset_done", 128'(done), 128'(0));
      chk("reset_crc_ok", 128'(crc_ok), 128'(0));
      chk("reset_crc_calc", 128'(crc_calc), 128'(0));
      chk("reset_crc_rx", 128'(crc_rx), 128'(0));
      chk("reset_frame", 128'(frame), 128'(0));
      chk("reset_all_zero", 128'(all_zero), 128'(0));
      idle(3);
      rst  = 1'b0;
      rst2 = 1'b0;
      idle(2);

      // good ROM code, back-to-back bits, bit_valid held through the DONE cycle
      pulse_start1();
      chk("start_busy", 128'(busy), 128'(1));
      send1(ROM, 0, 64, 1);
      push1(1'b1, 1'b0, 8'hA2, 1'b0, 8'hA2, ROM);
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      idle(4);
      bit_valid = 1'b0;
      chk("hold_frame", 128'(frame), 128'(ROM));
      chk("hold_crc_ok", 128'(crc_ok), 128'(1));

      // corrupted byte 3, spaced bits
      pulse_start1();
      send1(ROM_BAD, 0, 64, 5);
      push1(1'b0, 1'b0, 8'hA2, 1'b1, 8'hA2, ROM_BAD);
      idle(3);

      // shorted bus
      pulse_start1();
      send1(64'h0, 0, 64, 1);
      push1(1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 64'h0);
      idle(3);

      // abort after 20 bits, then bits with no start are ignored
      pulse_start1();
      send1(ROM, 0, 20, 1);
      abort = 1'b1;
      idle(1);
      abort = 1'b0;
      send1(ROM, 0, 64, 1);
      idle(3);
      chk("abort_busy", 128'(busy), 128'(0));
      chk("abort_crc_ok", 128'(crc_ok), 128'(0));
      chk("abort_partial_frame", 128'(frame), 128'(64'h81C02));
      pulse_start1();
      send1(ROM, 0, 64, 1);
      push1(1'b1, 1'b0, 8'hA2, 1'b0, 8'hA2, ROM);
      idle(3);

      // abort coinciding with the last bit
      pulse_start1();
      send1(ROM, 0, 63, 1);
      abort     = 1'b1;
      bit_valid = 1'b1;
      bit_in    = ROM[63];
      idle(1);
      abort     = 1'b0;
      bit_valid = 1'b0;
      idle(3);
      chk("abort_last_busy", 128'(busy), 128'(0));
      chk("abort_last_crc_ok", 128'(crc_ok), 128'(0));

      // start together with bit 30 restarts the frame and drops the bit
      pulse_start1();
      send1(ROM, 0, 30, 1);
      start     = 1'b1;
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      idle(1);
      start     = 1'b0;
      bit_valid = 1'b0;
      send1(ROM, 0, 64, 1);
      push1(1'b1, 1'b0, 8'hA2, 1'b0, 8'hA2, ROM);
      idle(3);

      // two-byte frame
      start2 = 1'b1;
      idle(1);
      start2 = 1'b0;
      send2(F2, 0, 16);
      begin
         exp_t e;
         e.ok = 1'b1; e.az = 1'b0; e.calc = 8'h5E; e.calc_ne = 1'b0; e.rx = 8'h5E;
         e.fr = 128'(F2); e.cyc = cyc;
         q2.push_back(e);
      end
      idle(3);

      // asynchronous reset at bit 9
      start2 = 1'b1;
      idle(1);
      start2 = 1'b0;
      send2(F2, 0, 9);
      #2;
      rst2 = 1'b1;
      #1;
      chk("rst2_busy", 128'(busy2), 128'(0));
      chk("rst2_crc_calc", 128'(crc_calc2), 128'(0));
      chk("rst2_crc_rx", 128'(crc_rx2), 128'(0));
      chk("rst2_frame", 128'(frame2), 128'(0));
      chk("rst2_crc_ok", 128'(crc_ok2), 128'(0));
      chk("rst2_all_zero", 128'(all_zero2), 128'(0));
      idle(1);
      rst2 = 1'b0;
      send2(F2, 9, 7);
      idle(4);
      chk("rst2_after_busy", 128'(busy2), 128'(0));

      chk("dut8_pending_expectations", 128'(q1.size()), 128'(0));
      chk("dut2_pending_expectations", 128'(q2.size()), 128'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
